// File: rtl/rv32i_if_pkg.sv
// rv32i_if_pkg: shared constants and the prefetch FIFO entry type for the
// rv32i instruction-fetch stage.
//   ILEN             instruction word width (always 32)
//   XLEN             PC width carried in a FIFO entry
//   NOP_IW           canonical NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC default reset PC
//   fetch_entry_t    {pc, iw, misalign_exc} payload held per FIFO slot
package rv32i_if_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_IW           = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] iw;
        logic            misalign_exc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/rv32i_sync_fifo.sv
// rv32i_sync_fifo: generic synchronous FIFO with a registered head.
// A push at the end of cycle N is visible on head_valid/head_data in N+1.
// head_data holds its last value while head_valid is low.
//   clk, rst_n      clock, synchronous active-low reset
//   flush           empties the FIFO (wins over push and pop)
//   push, push_data write port
//   pop             consume the head (ignored when empty)
//   head_valid      head entry present
//   head_data       head entry payload
//   count           number of stored entries
module rv32i_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    // Next pointer/count; the head register is reloaded from the next read slot.
    always_comb begin
        do_pop          = pop & (count != '0);
        do_push         = push & (do_pop | (count != CNT_W'(DEPTH)));
        rd_ptr_nxt      = rd_ptr + PTR_W'(do_pop);
        count_after_pop = count - CNT_W'(do_pop);
        count_nxt       = count_after_pop + CNT_W'(do_push);
    end

    // Storage array; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, count and registered head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PTR_W'(do_push);
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            head_valid <= (count_nxt != '0);
            // When the FIFO drains to empty this cycle, the new head can only
            // be the word being pushed (it is not in the array yet).
            if (count_after_pop == '0) begin
                if (do_push) begin
                    head_data <= push_data;
                end
            end else begin
                head_data <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/rv32i_if_prefetch.sv
// rv32i_if_prefetch: instruction-fetch stage with a small prefetch FIFO.
// Issues word addresses to a registered instruction memory (data returns the
// cycle after the request), queues {pc, iw} and hands them to ID over
// valid/ready. A redirect flushes queued and in-flight fetches.
// Optional feature macro: RV32I_IF_MISALIGN_EXC_EN adds misalign_exc; a
// misaligned jump queues one NOP entry flagged as an exception and halts
// fetching until the next jump or reset.
//   clk, reset    clock, synchronous active-low reset
//   memIfAddr     fetch word address (pc[XLEN-1:2])
//   memIfReq      fetch issued this cycle
//   memIfData     instruction word returned for last cycle's request
//   jump_enable   redirect request, jump_addr its target
//   id_valid      head entry valid; id_ready: ID takes the head
//   iw_out,pc_out head instruction word and its PC
//   misalign_exc  head entry came from a misaligned jump (macro only)
module rv32i_if_prefetch #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = rv32i_if_pkg::DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-3:0] memIfAddr,
    output logic            memIfReq,
    input  logic [31:0]     memIfData,
    input  logic            jump_enable,
    input  logic [XLEN-1:0] jump_addr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     iw_out,
`ifdef RV32I_IF_MISALIGN_EXC_EN
    output logic            misalign_exc,
`endif
    output logic [XLEN-1:0] pc_out
);

    import rv32i_if_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    logic            fetch_halt;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

`ifdef RV32I_IF_MISALIGN_EXC_EN
    logic            misalign_halt;
    logic            inflight_exc;
    assign fetch_halt = misalign_halt;
`else
    logic            unused_bits;
    assign fetch_halt  = 1'b0;
    assign unused_bits = ^{jump_addr[1:0], head_entry.misalign_exc};
`endif

    // Conservative credit: a same-cycle pop does not free a slot for issue.
    assign credit_used = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
    assign memIfReq    = reset & ~jump_enable & ~fetch_halt
                         & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign memIfAddr   = pc[XLEN-1:2];

    // PC and in-flight tracking; a jump cancels whatever was in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
`ifdef RV32I_IF_MISALIGN_EXC_EN
            inflight_exc  <= 1'b0;
            misalign_halt <= 1'b0;
`endif
        end else if (jump_enable) begin
            pc <= {jump_addr[XLEN-1:2], 2'b00};
`ifdef RV32I_IF_MISALIGN_EXC_EN
            // A misaligned target reuses the in-flight slot to queue the
            // exception NOP next cycle instead of fetching.
            if (jump_addr[1:0] != 2'b00) begin
                inflight      <= 1'b1;
                inflight_pc   <= jump_addr;
                inflight_exc  <= 1'b1;
                misalign_halt <= 1'b1;
            end else begin
                inflight      <= 1'b0;
                inflight_exc  <= 1'b0;
                misalign_halt <= 1'b0;
            end
`else
            inflight <= 1'b0;
`endif
        end else begin
            inflight <= memIfReq;
`ifdef RV32I_IF_MISALIGN_EXC_EN
            inflight_exc <= 1'b0;
`endif
            if (memIfReq) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
        end
    end

    // Entry captured from the memory response (or the exception NOP).
    always_comb begin
        push_entry              = '0;
        push_entry.pc           = inflight_pc;
        push_entry.iw           = memIfData;
        push_entry.misalign_exc = 1'b0;
`ifdef RV32I_IF_MISALIGN_EXC_EN
        if (inflight_exc) begin
            push_entry.iw           = NOP_IW;
            push_entry.misalign_exc = 1'b1;
        end
`endif
    end

    rv32i_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (jump_enable),
        .push       (inflight),
        .push_data  (push_entry),
        .pop        (id_ready),
        .head_valid (id_valid),
        .head_data  (head_entry),
        .count      (count)
    );

    assign iw_out = head_entry.iw;
    assign pc_out = head_entry.pc;
`ifdef RV32I_IF_MISALIGN_EXC_EN
    assign misalign_exc = head_entry.misalign_exc;
`endif

endmodule
